// File: rtl/mem_arbiter.sv
// Two-client line-memory arbiter: instruction refill and data miss (optional
// write-back then fill), round-robin grants, per-phase timeout abort.
module mem_arbiter #(
  parameter int LINE_W      = 512,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_i_req,
  input  logic [ADDR_W-1:0] i_i_addr,
  output logic [LINE_W-1:0] o_i_line,
  output logic              o_i_resp,
  input  logic              i_d_req,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic              i_d_evict,
  input  logic [ADDR_W-1:0] i_d_evict_addr,
  input  logic [LINE_W-1:0] i_d_evict_line,
  output logic [LINE_W-1:0] o_d_line,
  output logic              o_d_resp,
  output logic              o_err,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [LINE_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [LINE_W-1:0] i_mem_rdata,
  output logic              o_busy
);
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, I_FILL, D_EVICT, D_FILL} state_t;

  state_t            state, state_nxt;
  logic              last_d, last_d_nxt;        // 1: most recent grant went to data side
  logic [ADDR_W-1:0] fill_addr, fill_addr_nxt;  // data fill address held across the evict phase
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic              req_nxt, we_nxt, i_resp_nxt, d_resp_nxt, err_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [LINE_W-1:0] wdata_nxt, i_line_nxt, d_line_nxt;
  logic              gap, grant_d, timeout_hit;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:6], 6'b0};
  endfunction

  // A resp pulse marks the mandatory idle cycle between transactions.
  assign gap         = o_i_resp | o_d_resp;
  assign grant_d     = i_d_req && (!i_i_req || !last_d);
  assign cnt_inc     = cnt + 1'b1;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == TO_LIM);

  always_comb begin
    state_nxt     = state;
    last_d_nxt    = last_d;
    fill_addr_nxt = fill_addr;
    cnt_nxt       = cnt;
    req_nxt       = o_mem_req;
    we_nxt        = o_mem_we;
    addr_nxt      = o_mem_addr;
    wdata_nxt     = o_mem_wdata;
    i_line_nxt    = o_i_line;
    d_line_nxt    = o_d_line;
    i_resp_nxt    = 1'b0;
    d_resp_nxt    = 1'b0;
    err_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if ((i_i_req || i_d_req) && !gap) begin
          req_nxt = 1'b1;
          cnt_nxt = '0;
          if (grant_d) begin
            last_d_nxt    = 1'b1;
            fill_addr_nxt = line_addr(i_d_addr);
            if (i_d_evict) begin
              state_nxt = D_EVICT;
              we_nxt    = 1'b1;
              addr_nxt  = line_addr(i_d_evict_addr);
              wdata_nxt = i_d_evict_line;
            end else begin
              state_nxt = D_FILL;
              we_nxt    = 1'b0;
              addr_nxt  = line_addr(i_d_addr);
            end
          end else begin
            last_d_nxt = 1'b0;
            state_nxt  = I_FILL;
            we_nxt     = 1'b0;
            addr_nxt   = line_addr(i_i_addr);
          end
        end
      end
      default: begin
        if (i_mem_ack) begin
          if (state == D_EVICT) begin
            state_nxt = D_FILL;
            we_nxt    = 1'b0;
            addr_nxt  = fill_addr;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
            if (state == I_FILL) begin
              i_line_nxt = i_mem_rdata;
              i_resp_nxt = 1'b1;
            end else begin
              d_line_nxt = i_mem_rdata;
              d_resp_nxt = 1'b1;
            end
          end
        end else if (timeout_hit) begin
          // Abort: owner gets an error completion with a zero line; any pending fill is skipped.
          state_nxt = IDLE;
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          err_nxt   = 1'b1;
          if (state == I_FILL) begin
            i_line_nxt = '0;
            i_resp_nxt = 1'b1;
          end else begin
            d_line_nxt = '0;
            d_resp_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_d      <= 1'b0;
      fill_addr   <= '0;
      cnt         <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_i_line    <= '0;
      o_d_line    <= '0;
      o_i_resp    <= 1'b0;
      o_d_resp    <= 1'b0;
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_d      <= last_d_nxt;
      fill_addr   <= fill_addr_nxt;
      cnt         <= cnt_nxt;
      o_mem_req   <= req_nxt;
      o_mem_we    <= we_nxt;
      o_mem_addr  <= addr_nxt;
      o_mem_wdata <= wdata_nxt;
      o_i_line    <= i_line_nxt;
      o_d_line    <= d_line_nxt;
      o_i_resp    <= i_resp_nxt;
      o_d_resp    <= d_resp_nxt;
      o_err       <= err_nxt;
      o_busy      <= (state_nxt != IDLE);
    end
  end
endmodule
